// File: rtl/glb_stream_pkg.sv
// Shared widths, FSM states and header packing
// for the GLB-side stream source.
package glb_stream_pkg;

  localparam int DATA_W    = 17;
  localparam int PAYLOAD_W = 16;
  localparam int SIZE_W    = 12;
  localparam int ADDR_W    = 11;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    GAP,
    DONE
  } tx_state_t;

  function automatic logic [DATA_W-1:0] hdr_word(
    input logic [SIZE_W-1:0] sz
  );
    return {{(DATA_W-SIZE_W){1'b0}}, sz};
  endfunction

endpackage

// File: rtl/glb_stream_buf.sv
// One block buffer: flop array with a synchronous write
// port and a combinational read port.
module glb_stream_buf
  import glb_stream_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [PAYLOAD_W-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [PAYLOAD_W-1:0] rdata
);

  logic [PAYLOAD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/glb_stream_tx.sv
// Stream source: sends each preloaded block as a length
// header followed by its payload over a ready/valid link.
module glb_stream_tx
  import glb_stream_pkg::*;
#(
  parameter int NUM_BLOCKS = 1,
  parameter int DEPTH      = 2048,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_blk,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [PAYLOAD_W-1:0] cfg_wdata,
  input  logic                 cfg_size_en,
  input  logic [SIZE_W-1:0]    cfg_size,
  output logic [DATA_W-1:0]    data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 done,
  output logic                 busy
);

  tx_state_t state_q, state_d;
  logic              blk_q, blk_d;
  logic [SIZE_W-1:0] idx_q, idx_d;
  logic [3:0]        gap_q, gap_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SIZE_W-1:0] size_q [2];

  logic                 cfg_ok;
  logic                 xfer;
  logic                 eob;
  logic                 more;
  logic [ADDR_W-1:0]    rd_addr;
  logic [PAYLOAD_W-1:0] rd_word [2];
  logic [PAYLOAD_W-1:0] rd_data;

  assign cfg_ok = (state_q == IDLE || state_q == DONE)
                && (!cfg_blk || NUM_BLOCKS == 2);
  assign xfer   = valid_q && ready;
  assign more   = (NUM_BLOCKS == 2) && !blk_q;

  // Address of the word to present after this cycle's transfer
  assign rd_addr = (state_q == DATA)
                 ? idx_q[ADDR_W-1:0] + ADDR_W'(1)
                 : '0;
  assign rd_data = rd_word[blk_q];

  for (genvar b = 0; b < 2; b++) begin : g_buf
    if (b < NUM_BLOCKS) begin : g_on
      glb_stream_buf #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .we    (cfg_wr_en && cfg_ok && (cfg_blk == 1'(b))),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (rd_addr),
        .rdata (rd_word[b])
      );
    end else begin : g_off
      assign rd_word[b] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q[0] <= '0;
      size_q[1] <= '0;
    end else if (cfg_size_en && cfg_ok) begin
      size_q[cfg_blk] <= (cfg_size > SIZE_W'(DEPTH))
                       ? SIZE_W'(DEPTH) : cfg_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_q <= IDLE;
      blk_q   <= 1'b0;
      idx_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    done_d  = done_q;
    valid_d = valid_q;
    data_d  = data_q;
    eob     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HDR;
          blk_d   = 1'b0;
          done_d  = 1'b0;
          valid_d = 1'b1;
          data_d  = hdr_word(size_q[0]);
        end
      end
      HDR: begin
        if (xfer) begin
          if (size_q[blk_q] != '0) begin
            state_d = DATA;
            idx_d   = '0;
            data_d  = {1'b0, rd_data};
          end else begin
            eob = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          if (idx_q == size_q[blk_q] - 1'b1) begin
            eob = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = {1'b0, rd_data};
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = HDR;
          blk_d   = ~blk_q;
          valid_d = 1'b1;
          data_d  = hdr_word(size_q[~blk_q]);
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (eob) begin
      if (more && GAP_CYCLES == 0) begin
        state_d = HDR;
        blk_d   = ~blk_q;
        data_d  = hdr_word(size_q[~blk_q]);
      end else if (more) begin
        state_d = GAP;
        gap_d   = 4'(GAP_CYCLES - 1);
        valid_d = 1'b0;
        data_d  = '0;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
        valid_d = 1'b0;
        data_d  = '0;
      end
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign busy  = (state_q == HDR) || (state_q == DATA)
              || (state_q == GAP);

endmodule
